// File: rtl/seq1011_gen.sv
// Serial test-pattern source for the 1011 detector: shifts a loaded or LFSR frame out MSB first
// and keeps a reference count of the overlapping 1011 patterns it emitted.
module seq1011_gen #(
    parameter int unsigned WIDTH     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] word,
    input  logic [4:0]       len,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       match_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    localparam logic [4:0] WidthLen = 5'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [2:0]       hist_q, hist_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [7:0]       match_q, match_d;

    logic [15:0]      lfsr_step;
    logic [WIDTH-1:0] frame;
    logic [4:0]       eff_len;
    logic             load_bit;
    logic             new_bit;

    assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign frame     = mode ? lfsr_step[15 -: WIDTH] : word;
    assign eff_len   = (len == 5'd0 || len > WidthLen) ? WidthLen : len;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        hist_d   = hist_q;
        lfsr_d   = lfsr_q;
        bit_d    = bit_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        match_d  = match_q;
        load_bit = 1'b0;
        new_bit  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (mode) lfsr_d = lfsr_step;
                    sreg_d   = frame;
                    cnt_d    = eff_len;
                    hist_d   = 3'b000;
                    match_d  = 8'd0;
                    load_bit = 1'b1;
                    new_bit  = frame[WIDTH-1];
                    valid_d  = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                if (cnt_q > 5'd1) begin
                    sreg_d   = sreg_q << 1;
                    cnt_d    = cnt_q - 5'd1;
                    load_bit = 1'b1;
                    new_bit  = sreg_q[WIDTH-2];
                end else begin
                    bit_d   = 1'b0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = 5'd0;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: begin
                bit_d   = 1'b0;
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase

        // hist_d is already cleared here when this is the first bit of a frame
        if (load_bit) begin
            bit_d = new_bit;
            if ({hist_d, new_bit} == 4'b1011 && match_d != 8'hFF) match_d = match_d + 8'd1;
            hist_d = {hist_d[1:0], new_bit};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= 5'd0;
            hist_q  <= 3'b000;
            lfsr_q  <= LFSR_SEED;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 8'd0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            lfsr_q  <= lfsr_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign bit_out   = bit_q;
    assign bit_valid = valid_q;
    assign done      = done_q;
    assign match_cnt = match_q;
    assign busy      = (state_q != StIdle);
    assign state     = state_q;

endmodule
